pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on the rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: imem_busy  in  1  instruction fetch not complete this cycle.
REQ-004 SHALL have ports: dmem_busy  in  1  data access in MEM not complete this cycle.
REQ-005 SHALL have ports: ex_redirect  in  1  branch/jump resolved taken in EX.
REQ-006 SHALL have ports: ex_mem_read  in  1  EX holds a load; ex_rd  in  5  its destination.
REQ-007 SHALL have ports: id_rs1, id_rs2  in  5 each  ID sources; id_use_rs1, id_use_rs2  in  1 each  source valid.
REQ-008 SHALL have ports: switch_req  in  1  debug-mode switch request.
REQ-009 SHALL have ports: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush  out  1 each  pipeline-register controls.
REQ-010 SHALL have ports: switch_mode  out  1  pipeline halted for debug; redirect_pending  out  1  fetch result to be discarded.
REQ-011 SHALL have ports: stall_cycles, flush_events  out  32 each  performance counters.

Function
REQ-012 Control outputs SHALL be combinational from registered state and current inputs; state is {fsm, drain_cnt[2:0], redirect_pending}.
REQ-013 FSM states SHALL be RUN, DRAIN, HALT.
REQ-014 RUN, priority 1: dmem_busy=1 SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush; all other flushes 0.
REQ-015 RUN, priority 2: ex_redirect=1 SHALL assert ifid_flush and idex_flush; pc_stall=0.
REQ-016 RUN, priority 2: if ex_redirect=1 and imem_busy=1, redirect_pending SHALL set next cycle.
REQ-017 RUN, priority 3: load-use, defined as ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)), SHALL assert pc_stall, ifid_stall, idex_flush.
REQ-018 RUN, priority 4: imem_busy=1 SHALL assert pc_stall and ifid_flush.
REQ-019 While redirect_pending=1 and imem_busy=0, ifid_flush SHALL assert and redirect_pending SHALL clear next cycle.
REQ-020 While redirect_pending=1 and imem_busy=1, redirect_pending SHALL hold.
REQ-021 Lower-priority conditions SHALL be suppressed in any cycle where a higher-priority one holds.
REQ-022 RUN with switch_req=1 and dmem_busy=0 SHALL go to DRAIN next cycle with drain_cnt=3.
REQ-023 In DRAIN, pc_stall=1 and ifid_flush=1 SHALL hold (bubbles enter pipeline).
REQ-024 In DRAIN, drain_cnt SHALL decrement each cycle dmem_busy=0; while dmem_busy=1 it SHALL hold and REQ-014 outputs SHALL apply in addition.
REQ-025 DRAIN with drain_cnt=0 and dmem_busy=0 SHALL go to HALT.
REQ-026 In DRAIN, ex_redirect SHALL be ignored.
REQ-027 In HALT, switch_mode=1 and pc_stall=1 SHALL hold; all other controls 0.
REQ-028 HALT with switch_req=0 SHALL return to RUN next cycle, switch_mode=0.
REQ-029 switch_mode SHALL be 1 only in HALT.
REQ-030 Deassertion of switch_req during DRAIN SHALL not abort the drain.

Reset
REQ-031 rst=1 SHALL force fsm=RUN, drain_cnt=0, redirect_pending=0, counters=0 on the next edge.
REQ-032 rst=1 SHALL force all outputs to 0 in that cycle, including reset mid-DRAIN or mid-HALT.

Configuration
REQ-033 With PIPE_CTRL_PERF_EN defined, stall_cycles SHALL increment (wrapping at 2^32) each cycle pc_stall=1 and fsm!=HALT.
REQ-034 With PIPE_CTRL_PERF_EN defined, flush_events SHALL increment once per cycle in which ex_redirect causes a flush.
REQ-035 Without PIPE_CTRL_PERF_EN, both counter ports SHALL exist and be constant 0.

Verification
REQ-036 ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_stall=1, ifid_stall=1, idex_flush=1 for exactly that cycle; ex_rd=0 -> no stall.
REQ-037 ex_redirect=1 with load-use also true -> ifid_flush=1, idex_flush=1, pc_stall=0; flush_events +1 (PERF_EN).
REQ-038 ex_redirect=1 with imem_busy=1 for 3 cycles -> redirect_pending=1 for those cycles, then ifid_flush=1 one cycle on first imem_busy=0, then pending=0.
REQ-039 dmem_busy=1 together with ex_redirect=1 -> only freeze outputs (REQ-014); ifid_flush=0.
REQ-040 switch_req pulse in RUN, dmem_busy=1 on 2nd DRAIN cycle -> HALT reached after 5 cycles, switch_mode=1; switch_req=0 -> RUN next cycle.
REQ-041 rst asserted in HALT -> next cycle fsm=RUN, switch_mode=0, counters 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with debug drain/halt FSM
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_busy,
   input  logic        dmem_busy,
   input  logic        ex_redirect,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic        switch_req,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_stall,
   output logic        idex_flush,
   output logic        exmem_stall,
   output logic        memwb_flush,
   output logic        switch_mode,
   output logic        redirect_pending,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

   state_t     r_fsm;
   logic [2:0] r_drain_cnt;
   logic       r_redirect_pending;

   logic w_load_use;
   logic w_redirect_flush;
   logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall, w_idex_flush;
   logic w_exmem_stall, w_memwb_flush, w_switch_mode;

   assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

   assign w_redirect_flush = (r_fsm == RUN) && !dmem_busy && ex_redirect;

   always_comb begin
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_stall  = 1'b0;
      w_idex_flush  = 1'b0;
      w_exmem_stall = 1'b0;
      w_memwb_flush = 1'b0;
      w_switch_mode = 1'b0;
      case (r_fsm)
         RUN: begin
            if (dmem_busy) begin
               w_pc_stall    = 1'b1;
               w_ifid_stall  = 1'b1;
               w_idex_stall  = 1'b1;
               w_exmem_stall = 1'b1;
               w_memwb_flush = 1'b1;
            end else if (ex_redirect) begin
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
            end else if (w_load_use) begin
               w_pc_stall   = 1'b1;
               w_ifid_stall = 1'b1;
               w_idex_flush = 1'b1;
            end else if (imem_busy) begin
               w_pc_stall   = 1'b1;
               w_ifid_flush = 1'b1;
            end
            // Late fetch from the wrong path lands now: discard it
            if (!dmem_busy && r_redirect_pending && !imem_busy)
               w_ifid_flush = 1'b1;
         end
         DRAIN: begin
            w_pc_stall   = 1'b1;
            w_ifid_flush = 1'b1;
            if (dmem_busy) begin
               w_ifid_stall  = 1'b1;
               w_idex_stall  = 1'b1;
               w_exmem_stall = 1'b1;
               w_memwb_flush = 1'b1;
            end
         end
         HALT: begin
            w_pc_stall    = 1'b1;
            w_switch_mode = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm              <= RUN;
         r_drain_cnt        <= 3'd0;
         r_redirect_pending <= 1'b0;
      end else begin
         if (w_redirect_flush && imem_busy)
            r_redirect_pending <= 1'b1;
         else if (r_redirect_pending && !imem_busy && w_ifid_flush)
            r_redirect_pending <= 1'b0;

         case (r_fsm)
            RUN: if (switch_req && !dmem_busy) begin
               r_fsm       <= DRAIN;
               r_drain_cnt <= 3'd3;
            end
            DRAIN: if (!dmem_busy) begin
               if (r_drain_cnt == 3'd0) r_fsm       <= HALT;
               else                     r_drain_cnt <= r_drain_cnt - 3'd1;
            end
            HALT: if (!switch_req) r_fsm <= RUN;
            default: r_fsm <= RUN;
         endcase
      end
   end

   assign pc_stall         = w_pc_stall         & ~rst;
   assign ifid_stall       = w_ifid_stall       & ~rst;
   assign ifid_flush       = w_ifid_flush       & ~rst;
   assign idex_stall       = w_idex_stall       & ~rst;
   assign idex_flush       = w_idex_flush       & ~rst;
   assign exmem_stall      = w_exmem_stall      & ~rst;
   assign memwb_flush      = w_memwb_flush      & ~rst;
   assign switch_mode      = w_switch_mode      & ~rst;
   assign redirect_pending = r_redirect_pending & ~rst;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= 32'd0;
         r_flush_events <= 32'd0;
      end else begin
         if (w_pc_stall && (r_fsm != HALT)) r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_redirect_flush)              r_flush_events <= r_flush_events + 32'd1;
      end
   end

   assign stall_cycles = rst ? 32'd0 : r_stall_cycles;
   assign flush_events = rst ? 32'd0 : r_flush_events;
`else
   assign stall_cycles = 32'd0;
   assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized checks of pipe_ctrl against a reference model
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst, imem_busy, dmem_busy, ex_redirect, ex_mem_read;
   logic [4:0]  ex_rd, id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2, switch_req;
   logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic        exmem_stall, memwb_flush, switch_mode, redirect_pending;
   logic [31:0] stall_cycles, flush_events;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
      .ex_redirect(ex_redirect), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .switch_req(switch_req), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
      .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
      .exmem_stall(exmem_stall), .memwb_flush(memwb_flush), .switch_mode(switch_mode),
      .redirect_pending(redirect_pending), .stall_cycles(stall_cycles),
      .flush_events(flush_events)
   );

   int n_checks = 0;
   int n_errors = 0;

   // model: mode 0=running, 1=draining, 2=halted
   int          m_mode = 0;
   int          m_left = 0;
   bit          m_pend = 0;
   int unsigned m_stalls = 0;
   int unsigned m_flushes = 0;
   bit e_pc, e_ifs, e_iff, e_ixs, e_ixf, e_exs, e_mwf, e_sm;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_outputs();
      bit lu;
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      {e_pc, e_ifs, e_iff, e_ixs, e_ixf, e_exs, e_mwf, e_sm} = '0;
      if (m_mode == 2) begin
         e_pc = 1; e_sm = 1;
      end else if (m_mode == 1) begin
         e_pc = 1; e_iff = 1;
         if (dmem_busy) {e_ifs, e_ixs, e_exs, e_mwf} = 4'b1111;
      end else begin
         if (dmem_busy)        {e_pc, e_ifs, e_ixs, e_exs, e_mwf} = 5'b11111;
         else if (ex_redirect) {e_iff, e_ixf} = 2'b11;
         else if (lu)          {e_pc, e_ifs, e_ixf} = 3'b111;
         else if (imem_busy)   {e_pc, e_iff} = 2'b11;
         if (!dmem_busy && m_pend && !imem_busy) e_iff = 1;
      end
   endtask

   task automatic step();
      bit rf;
      logic [31:0] exp_st, exp_fl;
      #1;
      model_outputs();
`ifdef PIPE_CTRL_PERF_EN
      exp_st = rst ? 32'd0 : m_stalls;
      exp_fl = rst ? 32'd0 : m_flushes;
`else
      exp_st = 32'd0;
      exp_fl = 32'd0;
`endif
      chk("pc_stall",         pc_stall,         e_pc  & !rst);
      chk("ifid_stall",       ifid_stall,       e_ifs & !rst);
      chk("ifid_flush",       ifid_flush,       e_iff & !rst);
      chk("idex_stall",       idex_stall,       e_ixs & !rst);
      chk("idex_flush",       idex_flush,       e_ixf & !rst);
      chk("exmem_stall",      exmem_stall,      e_exs & !rst);
      chk("memwb_flush",      memwb_flush,      e_mwf & !rst);
      chk("switch_mode",      switch_mode,      e_sm  & !rst);
      chk("redirect_pending", redirect_pending, m_pend & !rst);
      chk("stall_cycles",     stall_cycles,     exp_st);
      chk("flush_events",     flush_events,     exp_fl);
      if (rst) begin
         m_mode = 0; m_left = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         rf = (m_mode == 0) && !dmem_busy && ex_redirect;
         if (e_pc && m_mode != 2) m_stalls++;
         if (rf) m_flushes++;
         if (rf && imem_busy) m_pend = 1;
         else if (m_pend && !imem_busy && e_iff) m_pend = 0;
         case (m_mode)
            0: if (switch_req && !dmem_busy) begin m_mode = 1; m_left = 3; end
            1: if (!dmem_busy) begin
                  if (m_left == 0) m_mode = 2;
                  else m_left--;
               end
            default: if (!switch_req) m_mode = 0;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_idle();
      rst = 0; imem_busy = 0; dmem_busy = 0; ex_redirect = 0; ex_mem_read = 0;
      ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; switch_req = 0;
   endtask

   initial begin
      set_idle();
      rst = 1;
      @(negedge clk);
      step(); step();
      rst = 0;
      step();

      // load-use on rs2, then gone, then ex_rd=0
      ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
      #1; chk("lu_pc", pc_stall, 1); chk("lu_ifs", ifid_stall, 1); chk("lu_ixf", idex_flush, 1);
      step();
      set_idle();
      #1; chk("lu_gone_pc", pc_stall, 0);
      step();
      ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
      #1; chk("lu_x0_pc", pc_stall, 0);
      step();

      // redirect beats load-use
      set_idle();
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_redirect = 1;
      #1; chk("rd_lu_iff", ifid_flush, 1); chk("rd_lu_ixf", idex_flush, 1); chk("rd_lu_pc", pc_stall, 0);
      step();

      // redirect while fetch busy
      set_idle();
      ex_redirect = 1; imem_busy = 1;
      step();
      ex_redirect = 0;
      #1; chk("pend_1", redirect_pending, 1);
      step();
      #1; chk("pend_2", redirect_pending, 1);
      step();
      imem_busy = 0;
      #1; chk("pend_iff", ifid_flush, 1);
      step();
      #1; chk("pend_clr", redirect_pending, 0); chk("pend_iff0", ifid_flush, 0);
      step();

      // dmem freeze beats redirect
      dmem_busy = 1; ex_redirect = 1;
      #1; chk("frz_iff", ifid_flush, 0); chk("frz_exs", exmem_stall, 1); chk("frz_mwf", memwb_flush, 1);
      step();

      // drain with a dmem stall on the second drain cycle
      set_idle();
      switch_req = 1;
      step();
      switch_req = 0;
      step();
      dmem_busy = 1;
      step();
      dmem_busy = 0;
      step(); step();
      #1; chk("drain5_sm", switch_mode, 0);
      step();
      #1; chk("halt_sm", switch_mode, 1); chk("halt_pc", pc_stall, 1);
      step();
      #1; chk("run_sm", switch_mode, 0);
      step();

      // reset while halted
      switch_req = 1;
      repeat (6) step();
      #1; chk("halt2_sm", switch_mode, 1);
      rst = 1;
      #1; chk("rst_sm", switch_mode, 0); chk("rst_pc", pc_stall, 0);
      step();
      rst = 0; switch_req = 0;
      #1; chk("post_rst_sm", switch_mode, 0);
      chk("post_rst_st", stall_cycles, 0); chk("post_rst_fl", flush_events, 0);
      step();

      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         imem_busy   = ($urandom_range(0, 3) == 0);
         dmem_busy   = ($urandom_range(0, 4) == 0);
         ex_redirect = ($urandom_range(0, 5) == 0);
         ex_mem_read = ($urandom_range(0, 2) == 0);
         ex_rd       = 5'($urandom_range(0, 3));
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         switch_req  = ($urandom_range(0, 9) < 2);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
